// File: rtl/dft_scan_responder_pkg.sv
// Shared DFT definitions: controller state encodings, word geometry and a
// ceil-divide helper used to size word-oriented structures.
package dft_scan_responder_pkg;

  // Packed output word width; fixed for every scan responder instance.
  localparam int unsigned DftWordW = 32;
  // Bits needed to index a bit position inside one packed word.
  localparam int unsigned WordIdxW = 5;

  // Controller state encodings.
  localparam int unsigned StW = 3;
  typedef logic [StW-1:0] dft_state_t;

  localparam dft_state_t StIdle    = 3'd0;
  localparam dft_state_t StAck     = 3'd1;
  localparam dft_state_t StShift   = 3'd2;
  localparam dft_state_t StFlush   = 3'd3;
  localparam dft_state_t StCommit  = 3'd4;
  localparam dft_state_t StRelease = 3'd5;

  // Number of b-sized pieces needed to cover a items.
  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/dft_scan_responder_word_packer.sv
// Serial-to-word packer: collects one scan bit per sample, LSB first, and
// emits each completed (or final, zero-padded) word with a one-cycle strobe.
module dft_word_packer
  import dft_scan_responder_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_i,
  input  logic                sample_i,
  input  logic                bit_i,
  output logic                last_o,
  output logic                strobe_o,
  output logic [DftWordW-1:0] data_o
);

  localparam int unsigned CntW = $clog2(CHAIN_LEN + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(CHAIN_LEN - 1);
  localparam logic [WordIdxW-1:0] TopPos = WordIdxW'(DftWordW - 1);

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [WordIdxW-1:0] pos_q, pos_d;
  logic [DftWordW-1:0] word_q, word_d;
  logic [DftWordW-1:0] data_q, data_d;
  logic                strobe_q, strobe_d;
  logic [DftWordW-1:0] word_full;
  logic                word_done;

  // The bit being sampled now is the last one of the chain.
  assign last_o = (cnt_q == LastIdx);

  // Next-state packing: insert the bit, hand the word out when full or final.
  always_comb begin
    cnt_d     = cnt_q;
    pos_d     = pos_q;
    word_d    = word_q;
    data_d    = data_q;
    strobe_d  = 1'b0;
    word_full = word_q;
    word_done = 1'b0;
    if (clear_i) begin
      cnt_d  = '0;
      pos_d  = '0;
      word_d = '0;
    end else if (sample_i) begin
      word_full[pos_q] = bit_i;
      word_done        = last_o || (pos_q == TopPos);
      if (word_done) begin
        // Word register restarts at zero, so a short final word is zero-padded.
        data_d   = word_full;
        strobe_d = 1'b1;
        word_d   = '0;
        pos_d    = '0;
      end else begin
        word_d = word_full;
        pos_d  = pos_q + WordIdxW'(1);
      end
      cnt_d = last_o ? '0 : cnt_q + CntW'(1);
    end
  end

  // Packer state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      pos_q    <= '0;
      word_q   <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      pos_q    <= pos_d;
      word_q   <= word_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
    end
  end

  assign strobe_o = strobe_q;
  assign data_o   = data_q;

endmodule

// File: rtl/dft_scan_responder.sv
// Scan unload responder: four-phase request/commit handshake around a
// non-destructive recirculating unload of one scan chain into 32-bit words.
module dft_scan_responder
  import dft_scan_responder_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 256,
  parameter int unsigned WORD_W    = dft_scan_responder_pkg::DftWordW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              val_op_i,
  output logic              op_ack_o,
  output logic              op_commit_o,
  input  logic              commit_ack_i,
  output logic              output_strobe_o,
  output logic [WORD_W-1:0] output_data_o,
  output logic              scan_en_o,
  input  logic              scan_out_i,
  output logic              scan_in_o
);

  dft_state_t state_q, state_d;
  logic       shifting;
  logic       last_bit;

  // Controller next state; val_op and commit_ack only matter where listed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (val_op_i) state_d = StAck;
      StAck:     if (!val_op_i) state_d = StShift;
      StShift:   if (last_bit) state_d = StFlush;
      StFlush:   state_d = StCommit;
      StCommit:  if (commit_ack_i) state_d = StRelease;
      StRelease: if (!commit_ack_i) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore outputs decoded from the registered state.
  assign shifting    = (state_q == StShift);
  assign scan_en_o   = shifting;
  assign op_ack_o    = (state_q == StAck);
  assign op_commit_o = (state_q == StCommit);

  // Feeding the tail back into the head leaves the chain contents intact.
  assign scan_in_o = shifting ? scan_out_i : 1'b0;

  // Packer is cleared while idle so every unload starts at bit 0.
  dft_word_packer #(
    .CHAIN_LEN(CHAIN_LEN)
  ) u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (state_q == StIdle),
    .sample_i (shifting),
    .bit_i    (scan_out_i),
    .last_o   (last_bit),
    .strobe_o (output_strobe_o),
    .data_o   (output_data_o)
  );

endmodule

// File: tb/tb_dft_scan_responder.sv
// Bench for dft_scan_responder: three instances (70, 64 and 1 bit chains),
// each attached to a behavioural recirculating chain.
module tb_dft_scan_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst;
  logic [2:0]  val_op;
  logic [2:0]  commit_ack;
  wire  [2:0]  op_ack;
  wire  [2:0]  op_commit;
  wire  [2:0]  strobe;
  wire  [2:0]  scan_en;
  wire  [2:0]  scan_in;
  wire  [2:0]  scan_out;
  wire  [31:0] odata [3];

  logic [127:0] chain [3];
  logic [127:0] load_val [3];
  logic [2:0]   load_req;
  logic [127:0] snap [3];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Monitor bookkeeping per instance.
  int ack_cnt [3];
  int en_cnt [3];
  int st_cnt [3];
  int commit_cnt [3];
  int overlap [3];
  int stray [3];
  int last_ack_cyc [3];
  int first_en_cyc [3];
  int last_st_cyc [3];
  int first_commit_cyc [3];
  logic [31:0] words [3][8];

  dft_scan_responder #(.CHAIN_LEN(70)) u_dut70 (
    .clk(clk), .reset(rst[0]), .val_op_i(val_op[0]), .op_ack_o(op_ack[0]),
    .op_commit_o(op_commit[0]), .commit_ack_i(commit_ack[0]), .output_strobe_o(strobe[0]),
    .output_data_o(odata[0]), .scan_en_o(scan_en[0]), .scan_out_i(scan_out[0]),
    .scan_in_o(scan_in[0])
  );

  dft_scan_responder #(.CHAIN_LEN(64)) u_dut64 (
    .clk(clk), .reset(rst[1]), .val_op_i(val_op[1]), .op_ack_o(op_ack[1]),
    .op_commit_o(op_commit[1]), .commit_ack_i(commit_ack[1]), .output_strobe_o(strobe[1]),
    .output_data_o(odata[1]), .scan_en_o(scan_en[1]), .scan_out_i(scan_out[1]),
    .scan_in_o(scan_in[1])
  );

  dft_scan_responder #(.CHAIN_LEN(1)) u_dut1 (
    .clk(clk), .reset(rst[2]), .val_op_i(val_op[2]), .op_ack_o(op_ack[2]),
    .op_commit_o(op_commit[2]), .commit_ack_i(commit_ack[2]), .output_strobe_o(strobe[2]),
    .output_data_o(odata[2]), .scan_en_o(scan_en[2]), .scan_out_i(scan_out[2]),
    .scan_in_o(scan_in[2])
  );

  function automatic int len_of(input int i);
    case (i)
      0:       return 70;
      1:       return 64;
      default: return 1;
    endcase
  endfunction

  // Chain of length L: bit 0 is the tail; a shift moves scan_in into bit L-1.
  function automatic logic [127:0] rotate(input logic [127:0] c, input logic b, input int l);
    logic [127:0] t;
    t = c >> 1;
    t[l-1] = b;
    return t;
  endfunction

  // Expected word k: chain bit n lands in word n/32 at bit n%32, zero above the end.
  function automatic logic [31:0] model_word(input logic [127:0] p, input int l, input int k);
    logic [31:0] w;
    w = '0;
    for (int n = 32 * k; n < 32 * k + 32; n++) begin
      if (n < l) w[n-32*k] = p[n];
    end
    return w;
  endfunction

  assign scan_out[0] = chain[0][0];
  assign scan_out[1] = chain[1][0];
  assign scan_out[2] = chain[2][0];

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural scan chains.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (load_req[i]) chain[i] <= load_val[i];
      else if (scan_en[i]) chain[i] <= rotate(chain[i], scan_in[i], len_of(i));
    end
  end

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (op_ack[i]) begin
        ack_cnt[i]++;
        last_ack_cyc[i] = cyc;
      end
      if (scan_en[i]) begin
        if (en_cnt[i] == 0) first_en_cyc[i] = cyc;
        en_cnt[i]++;
      end
      if (strobe[i]) begin
        if (st_cnt[i] < 8) words[i][st_cnt[i]] = odata[i];
        st_cnt[i]++;
        last_st_cyc[i] = cyc;
      end
      if (op_commit[i]) begin
        if (commit_cnt[i] == 0) first_commit_cyc[i] = cyc;
        commit_cnt[i]++;
      end
      if (op_commit[i] && strobe[i]) overlap[i]++;
      if (!scan_en[i] && scan_in[i]) stray[i]++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic clear_mon(input int i);
    ack_cnt[i] = 0;
    en_cnt[i] = 0;
    st_cnt[i] = 0;
    commit_cnt[i] = 0;
    overlap[i] = 0;
    stray[i] = 0;
    last_ack_cyc[i] = -1;
    first_en_cyc[i] = -1;
    last_st_cyc[i] = -1;
    first_commit_cyc[i] = -1;
  endtask

  task automatic load_chain(input int i, input logic [127:0] v);
    @(posedge clk);
    #1;
    load_val[i] = v & ((128'd1 << len_of(i)) - 128'd1);
    load_req[i] = 1'b1;
    @(posedge clk);
    #1;
    load_req[i] = 1'b0;
  endtask

  task automatic recover(input int i);
    val_op[i] = 1'b0;
    commit_ack[i] = 1'b0;
    @(posedge clk);
    #1 rst[i] = 1'b1;
    @(posedge clk);
    #1 rst[i] = 1'b0;
  endtask

  // Request an unload with val_op held for vc cycles.
  task automatic start_op(input int i, input int vc);
    clear_mon(i);
    snap[i] = chain[i];
    @(posedge clk);
    #1 val_op[i] = 1'b1;
    repeat (vc) @(posedge clk);
    #1 val_op[i] = 1'b0;
  endtask

  // Complete the handshake and check the whole transaction. With probe set,
  // val_op is raised during commit_ack and the follow-on request is measured.
  task automatic finish_op(input int i, input int vc, input int cd, input int ch,
                           input bit probe);
    int l, nw, t, d;
    string p;
    l = len_of(i);
    nw = (l + 31) / 32;
    p = $sformatf("d%0d", l);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!op_commit[i] && t < l + 40);
    check({p, "_commit_seen"}, op_commit[i], 1);
    if (!op_commit[i]) begin
      recover(i);
      return;
    end
    repeat (cd - 1) @(posedge clk);
    #1;
    commit_ack[i] = 1'b1;
    if (probe) val_op[i] = 1'b1;
    repeat (ch) @(posedge clk);
    #1 commit_ack[i] = 1'b0;
    d = cyc;
    if (!probe) begin
      repeat (2) @(posedge clk);
      @(negedge clk);
    end
    check({p, "_ack_cycles"}, ack_cnt[i], vc);
    check({p, "_shift_follows_ack"}, first_en_cyc[i], last_ack_cyc[i] + 1);
    check({p, "_scan_en_cycles"}, en_cnt[i], l);
    check({p, "_strobes"}, st_cnt[i], nw);
    for (int k = 0; k < nw; k++) begin
      check($sformatf("%s_word%0d", p, k), words[i][k], model_word(snap[i], l, k));
    end
    check({p, "_data_hold"}, odata[i], model_word(snap[i], l, nw - 1));
    check({p, "_commit_after_last_strobe"}, first_commit_cyc[i], last_st_cyc[i] + 1);
    check({p, "_commit_cycles"}, commit_cnt[i], cd);
    check({p, "_commit_strobe_overlap"}, overlap[i], 0);
    check({p, "_scan_in_idle"}, stray[i], 0);
    check({p, "_chain_restored"}, chain[i], snap[i]);
    if (probe) begin
      clear_mon(i);
      snap[i] = chain[i];
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!op_ack[i] && t < 10);
      check({p, "_release_to_ack"}, cyc - d, 2);
      @(posedge clk);
      #1 val_op[i] = 1'b0;
    end
  endtask

  typedef struct {
    int           dut;
    int           vc;
    int           cd;
    int           ch;
    bit           probe;
    logic [127:0] pat;
    int           exp_n;
    logic [31:0]  exp_w0;
    logic [31:0]  exp_wl;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [127:0] p70;
    logic [127:0] rp;
    logic [31:0]  saved [3];
    int           i, vc, t;

    p70 = '0;
    for (int n = 0; n < 70; n++) if (n % 3 == 0) p70[n] = 1'b1;
    vecs[0] = '{0, 1, 1, 1, 1'b0, p70, 3, 32'h49249249, 32'h00000024};
    vecs[1] = '{1, 5, 2, 1, 1'b0, 128'hDEADBEEF_12345678, 2, 32'h12345678, 32'hDEADBEEF};
    vecs[2] = '{0, 2, 10, 4, 1'b0, (128'd1 << 70) - 128'd1, 3, 32'hFFFFFFFF, 32'h0000003F};
    vecs[3] = '{2, 1, 1, 1, 1'b0, 128'd1, 1, 32'h00000001, 32'h00000001};
    vecs[4] = '{2, 3, 3, 2, 1'b0, 128'd0, 1, 32'h00000000, 32'h00000000};
    vecs[5] = '{1, 1, 1, 1, 1'b0, 128'hFFFFFFFF_FFFFFFFF, 2, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[6] = '{0, 2, 3, 4, 1'b1, p70 ^ 128'h3, 3, 32'h4924924A, 32'h00000024};

    rst = 3'b111;
    val_op = '0;
    commit_ack = '0;
    load_req = 3'b111;
    for (int k = 0; k < 3; k++) begin
      load_val[k] = '0;
      clear_mon(k);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_ctrl_%0d", k),
            {op_ack[k], op_commit[k], strobe[k], scan_en[k], scan_in[k]}, 0);
      check($sformatf("reset_data_%0d", k), odata[k], 0);
    end
    @(posedge clk);
    #1;
    rst = '0;
    load_req = '0;

    // Directed vectors.
    foreach (vecs[v]) begin
      load_chain(vecs[v].dut, vecs[v].pat);
      start_op(vecs[v].dut, vecs[v].vc);
      finish_op(vecs[v].dut, vecs[v].vc, vecs[v].cd, vecs[v].ch, vecs[v].probe);
      if (vecs[v].probe) begin
        // Back-to-back request raised during RELEASE: op_ack seen twice.
        finish_op(vecs[v].dut, 2, 2, 1, 1'b0);
      end else begin
        check($sformatf("vec%0d_strobes", v), st_cnt[vecs[v].dut], vecs[v].exp_n);
        check($sformatf("vec%0d_first_word", v), words[vecs[v].dut][0], vecs[v].exp_w0);
        check($sformatf("vec%0d_last_word", v), words[vecs[v].dut][vecs[v].exp_n-1],
              vecs[v].exp_wl);
      end
    end

    // Reset during SHIFT cycle 20 of the 70-bit unload.
    load_chain(0, {$urandom, $urandom, $urandom, $urandom});
    start_op(0, 1);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!scan_en[0] && t < 10);
    check("abort_shift_started", scan_en[0], 1);
    repeat (19) @(posedge clk);
    #1 rst[0] = 1'b1;
    @(posedge clk);
    #1 rst[0] = 1'b0;
    @(negedge clk);
    check("abort_ctrl_zero", {op_ack[0], op_commit[0], strobe[0], scan_en[0], scan_in[0]}, 0);
    check("abort_data_zero", odata[0], 0);
    clear_mon(0);
    repeat (80) @(posedge clk);
    check("abort_no_strobe", st_cnt[0], 0);
    check("abort_no_commit", commit_cnt[0], 0);
    start_op(0, 1);
    finish_op(0, 1, 1, 1, 1'b0);

    // Two unloads of the same chain must produce identical words.
    load_chain(0, {$urandom, $urandom, $urandom, $urandom});
    start_op(0, 1);
    finish_op(0, 1, 2, 1, 1'b0);
    for (int k = 0; k < 3; k++) saved[k] = words[0][k];
    start_op(0, 2);
    finish_op(0, 2, 1, 2, 1'b0);
    for (int k = 0; k < 3; k++) check($sformatf("recirc_word%0d", k), words[0][k], saved[k]);

    // Randomized transactions against the word model.
    for (int r = 0; r < 12; r++) begin
      i = $urandom_range(0, 2);
      rp = {$urandom, $urandom, $urandom, $urandom};
      vc = $urandom_range(1, 4);
      load_chain(i, rp);
      start_op(i, vc);
      finish_op(i, vc, $urandom_range(1, 6), $urandom_range(1, 4), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dft_scan_responder.md
DFT_SCAN_RESPONDER -- requirements
Module: dft_scan_responder

Interface
REQ-001 Parameter CHAIN_LEN, default 256, SHALL give the scan chain length in bits; legal range 1..4096.
REQ-002 Parameter WORD_W, default 32, SHALL give the output word width; it is fixed at 32 for all instances.
REQ-003 clk  input  1  SHALL be the rising-edge clock for all state.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 val_op  input  1  SHALL carry the initiator request to start one scan unload.
REQ-006 op_ack  output  1  SHALL acknowledge val_op.
REQ-007 op_commit  output  1  SHALL signal that the unload is complete.
REQ-008 commit_ack  input  1  SHALL carry the initiator acknowledge of op_commit.
REQ-009 output_strobe  output  1  SHALL be a one-cycle pulse marking output_data valid.
REQ-010 output_data  output  32  SHALL carry the packed scan word.
REQ-011 scan_en  output  1  SHALL be the scan-enable for the DUT chain.
REQ-012 scan_out  input  1  SHALL be the serial bit from the chain tail.
REQ-013 scan_in  output  1  SHALL be the serial bit to the chain head.

Function
REQ-014 The state machine SHALL have exactly the states IDLE, ACK, SHIFT, FLUSH, COMMIT and RELEASE.
REQ-015 IDLE SHALL go to ACK when val_op=1; otherwise it SHALL stay in IDLE.
REQ-016 In ACK, op_ack SHALL be 1; the state SHALL go to SHIFT on the first cycle with val_op=0 and SHALL hold while val_op=1 (level handshake, so multi-chain AND-reduction in the initiator is safe).
REQ-017 In SHIFT, scan_en SHALL be 1 for exactly CHAIN_LEN cycles, sampling scan_out on each rising edge.
- bit counter width: clog2(CHAIN_LEN+1).
REQ-018 scan_in SHALL equal scan_out while in SHIFT (non-destructive recirculating unload) and SHALL be 0 otherwise.
REQ-019 Scan bit n (0 = first sampled) SHALL map to output_data word n/32, bit n%32.
REQ-020 output_strobe SHALL pulse, registered, in the cycle after the edge that samples bit 32k+31 or bit CHAIN_LEN-1.
REQ-021 output_data SHALL hold the completed word while output_strobe=1 and SHALL hold its last value otherwise.
REQ-022 The last word SHALL be zero-padded above bit (CHAIN_LEN-1)%32.
REQ-023 The total strobe count SHALL be ceil(CHAIN_LEN/32).
REQ-024 SHIFT SHALL go to FLUSH on the edge that samples bit CHAIN_LEN-1.
REQ-025 FLUSH SHALL last one cycle, carries the final strobe, and SHALL go to COMMIT.
REQ-026 op_commit SHALL therefore never coincide with output_strobe.
REQ-027 In COMMIT, op_commit SHALL be 1 until commit_ack=1, then the state SHALL go to RELEASE.
REQ-028 In RELEASE, all handshake outputs SHALL be 0; the state SHALL go to IDLE when commit_ack=0 (four-phase).
REQ-029 val_op SHALL be ignored in every state except IDLE; commit_ack SHALL be ignored outside COMMIT and RELEASE.
REQ-030 If val_op=1 and commit_ack=1 in the same IDLE cycle, the block SHALL take ACK.
REQ-031 Back-to-back operations SHALL be supported: val_op seen in IDLE immediately after RELEASE SHALL start a new unload with the bit counter at 0 and the packing register cleared.
REQ-032 scan_en, op_ack and op_commit SHALL be decoded from registered state only (Moore outputs).

Reset
REQ-033 On reset=1 at a clock edge, state SHALL become IDLE, counters 0, packing register 0 and output_data 0.
REQ-034 After that edge, op_ack, op_commit, output_strobe, scan_en and scan_in SHALL all be 0.
REQ-035 Reset asserted mid-SHIFT SHALL abort with no further strobe and no op_commit; the chain contents are not restored.

Structure
REQ-036 State encodings, WORD_W and a ceil-divide constant function SHALL live in a shared DFT header included by this block and the control unit.
REQ-037 The serial-to-word packer (shift register, bit index, strobe generation) SHALL be the single sub-module dft_word_packer.
REQ-038 dft_scan_responder SHALL contain the FSM and scan_en/scan_in muxing.

Verification
REQ-039 Check CHAIN_LEN=70 with pattern bit n = n%3==0: val_op pulse -> op_ack, 70 scan_en cycles, 3 strobes with words 0x49249249, 0x92492492, 0x00000024, then op_commit.
REQ-040 Check CHAIN_LEN=64: val_op held 5 cycles -> op_ack high 5 cycles; SHIFT starts on the cycle val_op falls; 2 strobes; final strobe in FLUSH, op_commit the next cycle.
REQ-041 Check commit hold: commit_ack delayed 10 cycles -> op_commit stays 1 for 10 cycles; commit_ack held 4 cycles -> RELEASE 4 cycles, then IDLE.
REQ-042 Check reset on SHIFT cycle 20 of 70 -> every output 0 next cycle; no strobe or op_commit follows; a new val_op gives a full 70-cycle unload.
REQ-043 Check recirculation: two consecutive unloads of the same chain -> identical output_data sequences.
REQ-044 Check CHAIN_LEN=1 with scan_out=1 -> single strobe with output_data=0x00000001.
